// File: rtl/den_giao_thong_if.sv
// den_giao_thong_if: lamp bundle for the two-street traffic light.
// master drives the lamps, slave observes them.
interface den_giao_thong_if;
   logic [2:0] street_a;
   logic       street_a_pri_lamp;
   logic [2:0] street_b;
   logic       street_b_pri_lamp;

   modport master (
      output street_a,
      output street_a_pri_lamp,
      output street_b,
      output street_b_pri_lamp
   );

   modport slave (
      input street_a,
      input street_a_pri_lamp,
      input street_b,
      input street_b_pri_lamp
   );
endinterface

// File: rtl/den_giao_thong.sv
// den_giao_thong: fixed-time two-street traffic light controller.
// Define ALL_RED_EN to add all-red clearance phases between streets.
module den_giao_thong #(
   parameter int CLK_DIV       = 50000000,
   parameter int GREEN_A_TICKS = 30,
   parameter int GREEN_B_TICKS = 20,
   parameter int YELLOW_TICKS  = 3,
   parameter int ALL_RED_TICKS = 2
) (
   input logic              clk,
   input logic              rst_n,
   den_giao_thong_if.master lamps
);
   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_A_GREEN  = 3'd1,
      S_A_YELLOW = 3'd2,
      S_B_GREEN  = 3'd3,
      S_B_YELLOW = 3'd4,
      S_CLR_AB   = 3'd5,
      S_CLR_BA   = 3'd6
   } state_t;

   state_t      state;
   state_t      state_nx;
   state_t      next_ph;
   logic [31:0] pre_cnt;
   logic [31:0] ph_cnt;
   logic [31:0] ph_cnt_nx;
   logic [31:0] dur;
   logic        tick;
   logic        legal;
   logic [2:0]  lamp_a;
   logic [2:0]  lamp_b;
   logic        pri_a;
   logic        pri_b;

   assign tick = (pre_cnt == 32'(CLK_DIV - 1));

   // Time base runs freely; phase changes never disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_INIT;
         ph_cnt <= '0;
      end else begin
         state  <= state_nx;
         ph_cnt <= ph_cnt_nx;
      end
   end

   always_comb begin
      dur     = 32'd1;
      next_ph = S_INIT;
      legal   = 1'b1;
      lamp_a  = 3'b100;
      lamp_b  = 3'b100;
      pri_a   = 1'b0;
      pri_b   = 1'b0;
      case (state)
         S_INIT: begin
            dur     = 32'd1;
            next_ph = S_A_GREEN;
         end
         S_A_GREEN: begin
            dur     = 32'(GREEN_A_TICKS);
            next_ph = S_A_YELLOW;
            lamp_a  = 3'b001;
            pri_a   = 1'b1;
         end
         S_A_YELLOW: begin
            dur     = 32'(YELLOW_TICKS);
`ifdef ALL_RED_EN
            next_ph = S_CLR_AB;
`else
            next_ph = S_B_GREEN;
`endif
            lamp_a  = 3'b010;
            pri_a   = 1'b1;
         end
         S_B_GREEN: begin
            dur     = 32'(GREEN_B_TICKS);
            next_ph = S_B_YELLOW;
            lamp_b  = 3'b001;
            pri_b   = 1'b1;
         end
         S_B_YELLOW: begin
            dur     = 32'(YELLOW_TICKS);
`ifdef ALL_RED_EN
            next_ph = S_CLR_BA;
`else
            next_ph = S_A_GREEN;
`endif
            lamp_b  = 3'b010;
            pri_b   = 1'b1;
         end
`ifdef ALL_RED_EN
         S_CLR_AB: begin
            dur     = 32'(ALL_RED_TICKS);
            next_ph = S_B_GREEN;
         end
         S_CLR_BA: begin
            dur     = 32'(ALL_RED_TICKS);
            next_ph = S_A_GREEN;
         end
`endif
         default: legal = 1'b0;
      endcase

      state_nx  = state;
      ph_cnt_nx = ph_cnt;
      // Unreachable encodings fall back to a safe all-red restart.
      if (!legal) begin
         state_nx  = S_INIT;
         ph_cnt_nx = '0;
      end else if (tick) begin
         if (ph_cnt == dur - 32'd1) begin
            state_nx  = next_ph;
            ph_cnt_nx = '0;
         end else begin
            ph_cnt_nx = ph_cnt + 32'd1;
         end
      end
   end

   assign lamps.street_a          = lamp_a;
   assign lamps.street_a_pri_lamp = pri_a;
   assign lamps.street_b          = lamp_b;
   assign lamps.street_b_pri_lamp = pri_b;
endmodule

// File: tb/tb_den_giao_thong.sv
// tb_den_giao_thong: random-length runs and async resets against a
// phase-schedule model, on three parameter sets of den_giao_thong.
module tb_den_giao_thong;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;
   int   k = 0;

   always #10 clk = ~clk;

`ifdef ALL_RED_EN
   localparam int CLR_T = 1;
   localparam int CLR_D = 2;
`else
   localparam int CLR_T = 0;
   localparam int CLR_D = 0;
`endif

   // {a[2:0], a_pri, b[2:0], b_pri}
   localparam logic [7:0] RR = 8'b100_0_100_0;
   localparam logic [7:0] AG = 8'b001_1_100_0;
   localparam logic [7:0] AY = 8'b010_1_100_0;
   localparam logic [7:0] BG = 8'b100_0_001_1;
   localparam logic [7:0] BY = 8'b100_0_010_1;

   den_giao_thong_if l1 ();
   den_giao_thong_if l4 ();
   den_giao_thong_if ld ();

   den_giao_thong #(
      .CLK_DIV(1), .GREEN_A_TICKS(5), .GREEN_B_TICKS(4),
      .YELLOW_TICKS(2), .ALL_RED_TICKS(1)
   ) u1 (.clk(clk), .rst_n(rst_n), .lamps(l1));

   den_giao_thong #(
      .CLK_DIV(4), .GREEN_A_TICKS(5), .GREEN_B_TICKS(4),
      .YELLOW_TICKS(2), .ALL_RED_TICKS(1)
   ) u4 (.clk(clk), .rst_n(rst_n), .lamps(l4));

   den_giao_thong #(
      .CLK_DIV(1)
   ) ud (.clk(clk), .rst_n(rst_n), .lamps(ld));

   logic [7:0] o1, o4, od;
   assign o1 = {l1.street_a, l1.street_a_pri_lamp,
                l1.street_b, l1.street_b_pri_lamp};
   assign o4 = {l4.street_a, l4.street_a_pri_lamp,
                l4.street_b, l4.street_b_pri_lamp};
   assign od = {ld.street_a, ld.street_a_pri_lamp,
                ld.street_b, ld.street_b_pri_lamp};

   // Expected lamps after n ticks since reset release.
   function automatic logic [7:0] model(int n, int ga, int gb,
                                        int y, int clr);
      int m;
      if (n < 1) return RR;
      m = (n - 1) % (ga + y + clr + gb + y + clr);
      if (m < ga) return AG;
      m -= ga;
      if (m < y) return AY;
      m -= y;
      if (m < clr) return RR;
      m -= clr;
      if (m < gb) return BG;
      m -= gb;
      if (m < y) return BY;
      return RR;
   endfunction

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b (k=%0d)", tag, got, exp, k);
      end
   endtask

   task automatic inv(string tag, logic [7:0] o);
      logic [7:0] f;
      f = {4'b0000,
           $onehot(o[7:5]), $onehot(o[3:1]),
           (o[7:5] == 3'b100) || (o[3:1] == 3'b100),
           !(o[4] && o[0])};
      check(tag, f, 8'h0F);
   endtask

   task automatic check_all();
      check("u1_lamps", o1, model(k, 5, 4, 2, CLR_T));
      check("u4_lamps", o4, model(k / 4, 5, 4, 2, CLR_T));
      check("ud_lamps", od, model(k, 30, 20, 3, CLR_D));
      inv("u1_inv", o1);
      inv("u4_inv", o4);
      inv("ud_inv", od);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      check_all();
   endtask

   task automatic reset_mid();
      #($urandom_range(2, 7));
      rst_n = 1'b0;
      #1;
      k = 0;
      check_all();
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all();
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      #5;
      check_all();
      #10;
      check_all();
      #5;
      rst_n = 1'b1;

      step();
      check("first_a_green", o1, AG);
      repeat (120 + $urandom_range(0, 20)) step();

      guard = 0;
      while (model(k, 5, 4, 2, CLR_T) != BG && guard < 40) begin
         step();
         guard++;
      end
      check("bg_reached", o1, BG);
      reset_mid();
      step();
      check("restart_a_green", o1, AG);

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(5, 80)) step();
         reset_mid();
      end
      repeat (130) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
